// File: rtl/decode_format_stage.sv
// decode_format_stage: registered RISC-V instruction format decoder.
// Classifies the opcode into a one-hot format, extracts the register and
// funct fields, and builds the sign-extended immediate. A decoded output
// register plus one skid entry give full throughput under back-pressure.
// Also supports flush and keeps a saturating illegal-instruction counter.
module decode_format_stage #(
  parameter int XLEN    = 32,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_inst,
  input  logic [XLEN-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [7:0]         out_fmt,
  output logic               out_illegal,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [2:0]         out_funct3,
  output logic [6:0]         out_funct7,
  output logic [XLEN-1:0]    out_imm,
  output logic [COUNT_W-1:0] illegal_count
);

  // One fully decoded instruction, as held in the output or skid slot.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [7:0]      fmt;
    logic            illegal;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
  } entry_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  // Decode is done once, at the input, so both slots hold finished entries.
  function automatic entry_t decode(input logic [31:0] inst, input logic [XLEN-1:0] pc);
    entry_t     e;
    logic [31:0] imm32;
    e        = '0;
    e.pc     = pc;
    e.rd     = inst[11:7];
    e.rs1    = inst[19:15];
    e.rs2    = inst[24:20];
    e.funct3 = inst[14:12];
    e.funct7 = inst[31:25];
    case (inst[6:0])
      7'b0110011:                         e.fmt = 8'h01;
      7'b0010011, 7'b0000011, 7'b1100111: e.fmt = 8'h02;
      7'b0100011:                         e.fmt = 8'h04;
      7'b1100011:                         e.fmt = 8'h08;
      7'b0110111, 7'b0010111:             e.fmt = 8'h10;
      7'b1101111:                         e.fmt = 8'h20;
      7'b0001111:                         e.fmt = 8'h40;
      7'b1110011:                         e.fmt = 8'h80;
      7'b0011011:                         e.fmt = (XLEN == 64) ? 8'h02 : 8'h00;
      7'b0111011:                         e.fmt = (XLEN == 64) ? 8'h01 : 8'h00;
      default:                            e.fmt = 8'h00;
    endcase
    e.illegal = (e.fmt == 8'h00);
    // Immediates are assembled at 32 bits and then sign-extended to XLEN.
    case (e.fmt)
      8'h02, 8'h40, 8'h80: imm32 = {{20{inst[31]}}, inst[31:20]};
      8'h04:               imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      8'h08:               imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      8'h10:               imm32 = {inst[31:12], 12'b0};
      8'h20:               imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:             imm32 = 32'h0000_0000;
    endcase
    e.imm = XLEN'($signed(imm32));
    return e;
  endfunction

  entry_t               r_out;
  entry_t               r_skid;
  logic                 r_out_valid;
  logic                 r_skid_valid;
  logic                 r_in_ready;
  logic [COUNT_W-1:0]   r_cnt;

  entry_t               w_new;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_out_load;
  logic                 w_out_from_skid;
  logic                 w_skid_load;
  logic                 w_out_valid_nxt;
  logic                 w_skid_valid_nxt;

  assign w_new      = decode(in_inst, in_pc);
  assign w_in_fire  = in_valid && r_in_ready && !flush;
  assign w_out_fire = r_out_valid && out_ready;

  // Slot steering: skid drains into the output first so order is preserved.
  always_comb begin
    w_out_valid_nxt  = r_out_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_out_load       = 1'b0;
    w_out_from_skid  = 1'b0;
    w_skid_load      = 1'b0;
    if (flush) begin
      w_out_valid_nxt  = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (!r_out_valid || w_out_fire) begin
      if (r_skid_valid) begin
        w_out_load       = 1'b1;
        w_out_from_skid  = 1'b1;
        w_out_valid_nxt  = 1'b1;
        w_skid_load      = w_in_fire;
        w_skid_valid_nxt = w_in_fire;
      end else if (w_in_fire) begin
        w_out_load      = 1'b1;
        w_out_valid_nxt = 1'b1;
      end else begin
        w_out_valid_nxt = 1'b0;
      end
    end else begin
      if (w_in_fire) begin
        w_skid_load      = 1'b1;
        w_skid_valid_nxt = 1'b1;
      end else begin
        w_skid_load = 1'b0;
      end
    end
  end

  // State registers: slots, valids, registered in_ready and illegal counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_out_valid  <= w_out_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
      if (w_out_load) begin
        r_out <= w_out_from_skid ? r_skid : w_new;
      end
      if (w_skid_load) begin
        r_skid <= w_new;
      end
      if (w_out_fire && r_out.illegal && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + {{(COUNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign out_pc        = r_out.pc;
  assign out_fmt       = r_out.fmt;
  assign out_illegal   = r_out.illegal;
  assign out_rd        = r_out.rd;
  assign out_rs1       = r_out.rs1;
  assign out_rs2       = r_out.rs2;
  assign out_funct3    = r_out.funct3;
  assign out_funct7    = r_out.funct7;
  assign out_imm       = r_out.imm;
  assign illegal_count = r_cnt;

endmodule

// File: doc/decode_format_stage.md
Name: decode_format_stage

Overview:
- Registered successor to the combinational opcode classifier. Takes fetched instructions over a valid/ready handshake and classifies the format (R/I/S/B/U/J/FENCE/SYSTEM).
- Also extracts register and funct fields, builds the sign-extended immediate, and flags illegal opcodes.
- Generalised to XLEN = 32/64, which enables the RV64 OP-IMM-32/OP-32 opcodes.
- Sits between fetch and the register-read stage. A 2-entry skid buffer gives full throughput under back-pressure. Includes flush and a saturating illegal-instruction counter.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Sets imm/pc width and enables the RV64 opcodes.
- COUNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered instructions
- in_valid  in  1  input instruction valid
- in_ready  out  1  stage can accept an input this cycle
- in_inst  in  32  raw instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded entry valid
- out_ready  in  1  downstream accepts the entry
- out_pc  out  XLEN  pc passed through
- out_fmt  out  8  one-hot format: bit0 R, bit1 I, bit2 S, bit3 B, bit4 U, bit5 J, bit6 FENCE, bit7 SYSTEM
- out_illegal  out  1  unrecognised opcode
- out_rd, out_rs1, out_rs2  out  5 each  inst[11:7], inst[19:15], inst[24:20]
- out_funct3  out  3  inst[14:12]
- out_funct7  out  7  inst[31:25]
- out_imm  out  XLEN  sign-extended immediate
- illegal_count  out  COUNT_W  illegal instructions delivered, saturating

Behaviour:
- Reset: rst=1 at a clk edge forces out_valid=0, skid empty, illegal_count=0, and all out_* data registers to 0. in_ready is 0 while rst=1 and 1 in the first cycle after reset deasserts. Reset asserted mid-operation drops all held entries.
- Decode map, by opcode:
  - 0110011 → R
  - 0010011, 0000011, 1100111 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - 0001111 → FENCE
  - 1110011 → SYSTEM
  - XLEN=64 only: 0011011 → I, 0111011 → R
- Illegal: any other opcode, including inst[1:0]≠11, gives out_illegal=1 and out_fmt=0. Field outputs still carry the raw slices; out_imm=0.
- Immediates (sign bit inst[31], extended to XLEN):
  - I/FENCE/SYSTEM: inst[31:20]
  - S: {inst[31:25],inst[11:7]}
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}
  - U: {inst[31:12],12'b0}
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}
  - R: 0
- Latency: an input accepted at edge N is visible on out_* after edge N when the output register is empty or draining that cycle. Otherwise it is held in the skid entry.
- Handshake:
  - Input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
  - in_ready = !skid_valid. It is registered and does not depend combinationally on out_ready.
  - out_* hold stable while out_valid&&!out_ready.
  - Order is strictly preserved. When the output drains, the skid entry moves to the output register before any new input. A new input accepted that same cycle goes to the skid entry.
  - Sustained in_valid=out_ready=1 gives 1 instruction per cycle.
  - With both entries full, in_ready=0 and in_inst/in_pc are ignored.
- Flush: synchronous. The next cycle has out_valid=0 and the skid empty. An input offered in the flush cycle is dropped, even if in_ready=1. The output transfer in the flush cycle still counts toward illegal_count. rst has priority over flush.
- illegal_count: +1 on each output transfer with out_illegal=1. It saturates at 2^COUNT_W−1 and is cleared only by rst.

Test Plan:
1. XLEN=32, out_ready=1, in 0x00500093 → next cycle: out_valid=1, out_fmt=00000010, rd=1, rs1=0, imm=0x00000005, illegal=0.
2. B-type 0xFE000EE3 → out_fmt=00001000, imm=0xFFFFFFFC. LUI 0x123452B7 → out_fmt=00010000, rd=5, imm=0x12345000. XLEN=64 LUI 0x800002B7 → imm=0xFFFFFFFF80000000.
3. Back-pressure: out_ready=0, stream A,B,C with pc 0x0,0x4,0x8:
   - A is held on out_*, B goes to skid, in_ready=0 while C is held at the input.
   - Raise out_ready → outputs A,B,C in consecutive cycles, pcs in order, no loss or duplication.
4. Illegal handling:
   - 0x00000000 → out_illegal=1, fmt=0, illegal_count=1 after transfer.
   - 0x0000003B with XLEN=32 → illegal, count=2. With XLEN=64 → fmt=00000001, legal.
   - Force the counter to 0xFFFF (COUNT_W=16) via a stream of illegal instructions → it stays at 0xFFFF.
5. Flush with both entries full plus an input offered in the same cycle → next cycle out_valid=0, in_ready=1, none of the three ever emerge.
6. rst asserted mid-stream with 2 entries held → out_valid=0, count=0. Next accepted instruction decodes normally with 1-cycle latency.
